// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of a UART transmitter: a circular FIFO filled at
// full clock rate, drained one frame at a time using the transmitter's idle flag.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  tx_idle,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] FullCount = DEPTH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitDone
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q;
    logic                  tx_start_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  wr_accept;
    logic                  wr_drop;
    logic                  pop;

    // Status flags decode the registered count, so they lag by one edge.
    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != StIdle);

    assign wr_accept = wr_en && !full;
    assign wr_drop   = wr_en && full;
    assign pop       = (state_q == StIdle) && !empty && tx_idle;

    // Occupancy: a simultaneous write and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // Handshake: wait for the transmitter to go busy, then to return idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (pop)      state_d = StWaitAck;
            StWaitAck:  if (!tx_idle) state_d = StWaitDone;
            StWaitDone: if (tx_idle)  state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, count, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= wr_drop;
            tx_start_q <= pop;
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_idle;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Transmitter model / write stream state
    int stream_next;
    int stream_end;
    int frame_left;
    int frame_len;

    logic [7:0] log_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .tx_idle (tx_idle),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .busy    (busy)
    );

    // Record every transmitted word.
    always @(negedge clk) begin
        if (rst_n && tx_start) log_q.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of streaming writes plus the transmitter model.
    task automatic tick();
        if (stream_next < stream_end && !full) begin
            wr_en   = 1'b1;
            wr_data = 8'(stream_next);
            stream_next++;
        end else begin
            wr_en = 1'b0;
        end
        step();
        if (tx_start) begin
            tx_idle    = 1'b0;
            frame_left = frame_len;
        end else if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) tx_idle = 1'b1;
        end
    endtask

    task automatic run(input int target, input int budget);
        int t = 0;
        tx_idle    = 1'b1;
        frame_left = 0;
        while ((log_q.size() < target || frame_left > 0 || stream_next < stream_end)
               && t < budget) begin
            tick();
            t++;
        end
        wr_en = 1'b0;
        step();
        chk("drain_in_budget", 32'(t < budget), 1);
    endtask

    initial begin
        int  b;
        bit  ok;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        tx_idle     = 1'b1;
        frame_len   = 30;
        stream_next = 0;
        stream_end  = 0;
        frame_left  = 0;

        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single byte with idle transmitter
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("single_count_after_wr", count, 1);
        chk("single_empty_after_wr", empty, 0);
        chk("single_no_start_e0", tx_start, 0);
        step();
        chk("single_start_e1", tx_start, 1);
        chk("single_data_e1", tx_data, 8'hA5);
        chk("single_busy_e1", busy, 1);
        chk("single_count_after_pop", count, 0);
        step();
        chk("single_start_one_cycle", tx_start, 0);
        chk("single_busy_wait_ack", busy, 1);
        tx_idle = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!busy || tx_data !== 8'hA5 || tx_start) ok = 1'b0;
        end
        chk("single_hold_frame", ok, 1);
        tx_idle = 1'b1;
        step();
        chk("single_busy_falls", busy, 0);
        chk("single_data_held", tx_data, 8'hA5);
        chk("single_one_frame", log_q.size(), 1);

        // Fill and overflow with transmitter stalled
        tx_idle = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_no_overflow", overflow, 0);
        wr_data = 8'h10;
        step();
        wr_en = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        step();
        chk("ovf_one_cycle", overflow, 0);
        b = log_q.size();
        frame_len = 3;
        run(b + 16, 3000);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (log_q[b + i] !== 8'(i)) ok = 1'b0;
        chk("fill_order", ok, 1);
        chk("ovf_word_dropped", log_q.size(), b + 16);
        chk("fill_drained", empty, 1);

        // Wrap-around ordering with 30-cycle frames
        b = log_q.size();
        frame_len   = 30;
        stream_next = 0;
        stream_end  = 40;
        run(b + 40, 5000);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) if (log_q[b + i] !== 8'(i)) ok = 1'b0;
        chk("wrap_order", ok, 1);
        chk("wrap_total", log_q.size(), b + 40);

        // Simultaneous write and pop, then handshake stall
        b = log_q.size();
        tx_idle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h51 + i);
            step();
        end
        chk("sim_count_pre", count, 3);
        tx_idle = 1'b1;
        wr_data = 8'h5C;
        step();
        wr_en = 1'b0;
        chk("sim_count_same", count, 3);
        chk("sim_start", tx_start, 1);
        chk("sim_oldest", tx_data, 8'h51);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_start || !busy) ok = 1'b0;
        end
        chk("stall_wait_ack", ok, 1);
        tx_idle = 1'b0;
        step();
        tx_idle = 1'b1;
        step();
        chk("stall_wait_done_exit", busy, 0);
        frame_len = 5;
        run(b + 4, 2000);
        chk("sim_1st", log_q[b], 8'h51);
        chk("sim_2nd", log_q[b + 1], 8'h52);
        chk("sim_3rd", log_q[b + 2], 8'h53);
        chk("sim_4th", log_q[b + 3], 8'h5C);

        // Asynchronous reset mid-burst with count = 5
        tx_idle = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h61 + i);
            step();
        end
        wr_en = 1'b0;
        tx_idle = 1'b1;
        step();
        tx_idle = 1'b0;
        chk("mid_count", count, 5);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_tx_start", tx_start, 0);
        chk("async_busy", busy, 0);
        chk("async_tx_data", tx_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tx_idle = 1'b1;
        b = log_q.size();
        repeat (5) step();
        chk("post_rst_discarded", log_q.size(), b);
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        chk("post_rst_start", tx_start, 1);
        chk("post_rst_data", tx_data, 8'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
